// File: rtl/gigabit_egress_fifo.sv
// Store-and-forward egress buffer: filters 64-bit crossbar frames by destination,
// buffers whole frames, and replays committed frames as a 32-bit stream.
module gigabit_egress_fifo #(
  parameter int PORT_ID    = 0,
  parameter int PORT_BITS  = 6,
  parameter int DEPTH      = 512,
  parameter int META_DEPTH = 32
) (
  input  logic                 clk_fabric,
  input  logic                 rst,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  input  logic [63:0]          rx_tdata,
  input  logic [7:0]           rx_tkeep,
  input  logic                 rx_tlast,
  input  logic [PORT_BITS:0]   rx_tdest,
  input  logic [11:0]          rx_tuser,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [31:0]          tx_tdata,
  output logic [3:0]           tx_tkeep,
  output logic                 tx_tlast,
  output logic [11:0]          tx_tuser,
  output logic [15:0]          drop_count
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int MAW = $clog2(META_DEPTH);
  localparam int MPW = MAW + 1;
  localparam int MW  = 12 + PW;
  localparam logic [PORT_BITS-1:0] PORT_SEL = PORT_BITS'(PORT_ID);
  localparam logic [PW-1:0]        DEPTH_P  = PW'(DEPTH);
  localparam logic [MPW-1:0]       MDEPTH_P = MPW'(META_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DISCARD, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_LOW, R_HIGH} rstate_t;

  logic [71:0]    mem      [DEPTH];
  logic [MW-1:0]  meta_mem [META_DEPTH];

  wstate_t        ws_q, ws_d;
  rstate_t        rs_q, rs_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q;
  logic [PW-1:0]  wc_q, wc_d, rem_q;
  logic [11:0]    vlan_q, vlan_d;
  logic [MPW-1:0] mw_ptr_q, mr_ptr_q;
  logic [15:0]    drop_q;
  logic [71:0]    ram_q;
  logic [35:0]    hi_q;
  logic [MW-1:0]  meta_rd;
  logic [AW-1:0]  rd_addr;
  logic           tx_tvalid_q, tx_tlast_q;
  logic [31:0]    tx_tdata_q;
  logic [3:0]     tx_tkeep_q;
  logic [11:0]    tx_tuser_q;

  logic beat, match, ram_full, meta_full, meta_empty;
  logic ram_we, meta_push, drop_inc, rollback;
  logic pop, hs, skip, ld_first, ld_high, ld_next, fin, rd_adv;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rx_tready  = ~rst;
  assign beat       = rx_tvalid & rx_tready;
  assign match      = rx_tdest[PORT_BITS] | (rx_tdest[PORT_BITS-1:0] == PORT_SEL);
  assign ram_full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign meta_full  = (mw_ptr_q - mr_ptr_q) == MDEPTH_P;
  assign meta_empty = (mw_ptr_q == mr_ptr_q);

  always_ff @(posedge clk_fabric) begin
    if (rst) ws_q <= W_IDLE;
    else     ws_q <= ws_d;
  end

  always_comb begin
    ws_d = ws_q;
    case (ws_q)
      W_IDLE:
        if (beat && !rx_tlast) begin
          if (!match)                      ws_d = W_DISCARD;
          else if (meta_full || ram_full)  ws_d = W_DROP;
          else                             ws_d = W_STORE;
        end
      W_STORE:
        if (beat) begin
          if (rx_tlast)      ws_d = W_IDLE;
          else if (ram_full) ws_d = W_DROP;
        end
      default:
        if (beat && rx_tlast) ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    ram_we   = 1'b0;
    drop_inc = 1'b0;
    rollback = 1'b0;
    case (ws_q)
      W_IDLE: begin
        ram_we   = beat & match & ~meta_full & ~ram_full;
        drop_inc = beat & match & (meta_full | ram_full);
      end
      W_STORE: begin
        ram_we   = beat & ~ram_full;
        rollback = beat & ram_full;
        drop_inc = beat & ram_full;
      end
      default: ;
    endcase
    meta_push = ram_we & rx_tlast;
    wc_d      = (ws_q == W_IDLE) ? PW'(1) : wc_q + PW'(1);
    vlan_d    = (ws_q == W_IDLE) ? rx_tuser : vlan_q;
    wr_ptr_d  = rollback ? commit_q : (ram_we ? wr_ptr_q + PW'(1) : wr_ptr_q);
    commit_d  = meta_push ? wr_ptr_q + PW'(1) : commit_q;
  end

  always_ff @(posedge clk_fabric) begin
    if (ram_we) begin
      mem[wr_ptr_q[AW-1:0]] <= {rx_tkeep, rx_tdata};
      wc_q   <= wc_d;
      vlan_q <= vlan_d;
    end
    if (meta_push) meta_mem[mw_ptr_q[MAW-1:0]] <= {vlan_d, wc_d};
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      wr_ptr_q <= '0;
      commit_q <= '0;
      mw_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      if (meta_push) mw_ptr_q <= mw_ptr_q + MPW'(1);
      if (drop_inc)  drop_q   <= sat_inc16(drop_q);
    end
  end

  // Read side: outside IDLE the RAM always looks one word ahead so HIGH->LOW has no bubble.
  assign meta_rd = meta_mem[mr_ptr_q[MAW-1:0]];
  assign rd_addr = rd_ptr_q[AW-1:0] + AW'(rs_q != R_IDLE);
  assign hs      = tx_tvalid_q & tx_tready;
  assign skip    = (rem_q == PW'(1)) & (hi_q[35:32] == 4'd0);

  always_ff @(posedge clk_fabric) begin
    if (rst) rs_q <= R_IDLE;
    else     rs_q <= rs_d;
  end

  always_comb begin
    rs_d = rs_q;
    case (rs_q)
      R_IDLE:  if (!meta_empty) rs_d = R_FETCH;
      R_FETCH: rs_d = R_LOW;
      R_LOW:   if (hs) rs_d = skip ? R_IDLE : R_HIGH;
      R_HIGH:  if (hs) rs_d = (rem_q == PW'(1)) ? R_IDLE : R_LOW;
      default: rs_d = R_IDLE;
    endcase
  end

  always_comb begin
    pop      = (rs_q == R_IDLE) & ~meta_empty;
    ld_first = (rs_q == R_FETCH);
    ld_high  = (rs_q == R_LOW)  & hs & ~skip;
    ld_next  = (rs_q == R_HIGH) & hs & (rem_q != PW'(1));
    fin      = ((rs_q == R_LOW) & hs & skip) | ((rs_q == R_HIGH) & hs & (rem_q == PW'(1)));
    rd_adv   = ((rs_q == R_LOW) & hs & skip) | ((rs_q == R_HIGH) & hs);
  end

  always_ff @(posedge clk_fabric) begin
    ram_q <= mem[rd_addr];
    if (pop)                     rem_q <= meta_rd[PW-1:0];
    else if (rs_q == R_HIGH && hs) rem_q <= rem_q - PW'(1);
    if (ld_first || ld_next)     hi_q <= {ram_q[71:68], ram_q[63:32]};
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      mr_ptr_q    <= '0;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      tx_tkeep_q  <= '0;
      tx_tlast_q  <= 1'b0;
      tx_tuser_q  <= '0;
    end else begin
      if (pop)    mr_ptr_q <= mr_ptr_q + MPW'(1);
      if (rd_adv) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (pop)    tx_tuser_q <= meta_rd[MW-1:PW];
      if (ld_first || ld_next) begin
        tx_tvalid_q <= 1'b1;
        tx_tdata_q  <= ram_q[31:0];
        tx_tkeep_q  <= ram_q[67:64];
        tx_tlast_q  <= (ld_first ? (rem_q == PW'(1)) : (rem_q == PW'(2))) & (ram_q[71:68] == 4'd0);
      end else if (ld_high) begin
        tx_tdata_q  <= hi_q[31:0];
        tx_tkeep_q  <= hi_q[35:32];
        tx_tlast_q  <= (rem_q == PW'(1));
      end else if (fin) begin
        tx_tvalid_q <= 1'b0;
        tx_tlast_q  <= 1'b0;
      end
    end
  end

  assign tx_tvalid  = tx_tvalid_q;
  assign tx_tdata   = tx_tdata_q;
  assign tx_tkeep   = tx_tkeep_q;
  assign tx_tlast   = tx_tlast_q;
  assign tx_tuser   = tx_tuser_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_gigabit_egress_fifo.sv
// Directed bench for gigabit_egress_fifo: a default-depth instance and a DEPTH=16 instance
// share the rx data bus; each has its own rx_tvalid and tx_tready.
module tb_gigabit_egress_fifo;
  localparam int PID = 5;

  logic clk_fabric = 1'b0;
  always #5 clk_fabric = ~clk_fabric;

  logic        rst;
  logic        rx_tvalid_a, rx_tvalid_b;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tlast;
  logic [6:0]  rx_tdest;
  logic [11:0] rx_tuser;

  logic        rx_tready_a, tx_tvalid_a, tx_tready_a, tx_tlast_a;
  logic [31:0] tx_tdata_a;
  logic [3:0]  tx_tkeep_a;
  logic [11:0] tx_tuser_a;
  logic [15:0] drop_count_a;
  logic        rx_tready_b, tx_tvalid_b, tx_tready_b, tx_tlast_b;
  logic [31:0] tx_tdata_b;
  logic [3:0]  tx_tkeep_b;
  logic [11:0] tx_tuser_b;
  logic [15:0] drop_count_b;

  gigabit_egress_fifo #(.PORT_ID(PID), .PORT_BITS(6), .DEPTH(512), .META_DEPTH(32)) dut_a (
    .clk_fabric(clk_fabric), .rst(rst),
    .rx_tvalid(rx_tvalid_a), .rx_tready(rx_tready_a), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
    .tx_tvalid(tx_tvalid_a), .tx_tready(tx_tready_a), .tx_tdata(tx_tdata_a), .tx_tkeep(tx_tkeep_a),
    .tx_tlast(tx_tlast_a), .tx_tuser(tx_tuser_a), .drop_count(drop_count_a));

  gigabit_egress_fifo #(.PORT_ID(PID), .PORT_BITS(6), .DEPTH(16), .META_DEPTH(4)) dut_b (
    .clk_fabric(clk_fabric), .rst(rst),
    .rx_tvalid(rx_tvalid_b), .rx_tready(rx_tready_b), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast), .rx_tdest(rx_tdest), .rx_tuser(rx_tuser),
    .tx_tvalid(tx_tvalid_b), .tx_tready(tx_tready_b), .tx_tdata(tx_tdata_b), .tx_tkeep(tx_tkeep_b),
    .tx_tlast(tx_tlast_b), .tx_tuser(tx_tuser_b), .drop_count(drop_count_b));

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [11:0] u;
  } beat_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    t_last = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t prev_a;
  logic  stall_a = 1'b0;

  always @(posedge clk_fabric) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beats are recorded on the negedge before the posedge that completes the handshake.
  always @(negedge clk_fabric) begin
    if (!rst && tx_tvalid_a && tx_tready_a) qa.push_back({tx_tdata_a, tx_tkeep_a, tx_tlast_a, tx_tuser_a});
    if (!rst && tx_tvalid_b && tx_tready_b) qb.push_back({tx_tdata_b, tx_tkeep_b, tx_tlast_b, tx_tuser_b});
    if (!rst && stall_a)
      chk("stall_stable", {15'd0, tx_tvalid_a, tx_tdata_a, tx_tkeep_a, tx_tlast_a, tx_tuser_a},
          {15'd0, 1'b1, prev_a});
    stall_a <= tx_tvalid_a && !tx_tready_a && !rst;
    prev_a  <= {tx_tdata_a, tx_tkeep_a, tx_tlast_a, tx_tuser_a};
  end

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((seed * 29 + i * 7 + 3) & 255);
  endfunction

  function automatic beat_t exp_beat(input int len, input int k, input int nb,
                                     input logic [11:0] vlan, input int seed);
    beat_t e;
    e.d = '0;
    e.k = '0;
    for (int j = 0; j < 4; j++)
      if (4 * k + j < len) begin
        e.d[j*8 +: 8] = pat(seed, 4 * k + j);
        e.k[j] = 1'b1;
      end
    e.l = (k == nb - 1);
    e.u = vlan;
    return e;
  endfunction

  task automatic send_frame(input bit sel, input int len, input logic [6:0] dest,
                            input logic [11:0] vlan, input int seed);
    int nw;
    logic [63:0] d;
    logic [7:0]  k;
    nw = (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      @(posedge clk_fabric); #1;
      d = '0;
      k = '0;
      for (int b = 0; b < 8; b++)
        if (w * 8 + b < len) begin
          d[b*8 +: 8] = pat(seed, w * 8 + b);
          k[b] = 1'b1;
        end
      rx_tdata = d;
      rx_tkeep = k;
      rx_tlast = (w == nw - 1);
      rx_tdest = dest;
      rx_tuser = (w == 0) ? vlan : ~vlan;
      if (sel) rx_tvalid_b = 1'b1;
      else     rx_tvalid_a = 1'b1;
      if (w == nw - 1) t_last = cyc;
    end
    @(posedge clk_fabric); #1;
    rx_tvalid_a = 1'b0;
    rx_tvalid_b = 1'b0;
    rx_tlast    = 1'b0;
  endtask

  task automatic wait_q(input bit sel, input int n, input int bound);
    int i = 0;
    while (((sel ? qb.size() : qa.size()) < n) && i < bound) begin
      @(posedge clk_fabric); #1;
      i++;
    end
  endtask

  task automatic check_frame(input bit sel, input int len, input logic [11:0] vlan,
                             input int seed, input string tag);
    int nb;
    beat_t b;
    nb = (len + 3) / 4;
    wait_q(sel, nb, 400);
    chk({tag, "_count"}, 64'((sel ? qb.size() : qa.size()) >= nb), 64'd1);
    for (int k = 0; k < nb; k++) begin
      if ((sel ? qb.size() : qa.size()) == 0) break;
      if (sel) b = qb.pop_front();
      else     b = qa.pop_front();
      chk($sformatf("%s_beat%0d", tag, k), 64'(b), 64'(exp_beat(len, k, nb, vlan, seed)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    int g;
    rst = 1'b1;
    rx_tvalid_a = 1'b0; rx_tvalid_b = 1'b0;
    rx_tdata = '0; rx_tkeep = '0; rx_tlast = 1'b0; rx_tdest = '0; rx_tuser = '0;
    tx_tready_a = 1'b1; tx_tready_b = 1'b0;
    repeat (3) @(posedge clk_fabric);
    #1;
    chk("rst_tvalid", 64'(tx_tvalid_a), 64'd0);
    chk("rst_tdata", 64'(tx_tdata_a), 64'd0);
    chk("rst_tkeep", 64'(tx_tkeep_a), 64'd0);
    chk("rst_tlast", 64'(tx_tlast_a), 64'd0);
    chk("rst_tuser", 64'(tx_tuser_a), 64'd0);
    chk("rst_drop", 64'(drop_count_a), 64'd0);
    chk("rst_rx_tready", 64'(rx_tready_a), 64'd0);
    rst = 1'b0;
    @(posedge clk_fabric); #1;
    chk("rx_tready_run", 64'(rx_tready_a), 64'd1);

    // 64-byte unicast frame: latency, throughput, content
    send_frame(0, 64, {1'b0, 6'(PID)}, 12'h123, 1);
    g = 0;
    while (!tx_tvalid_a && g < 50) begin @(posedge clk_fabric); #1; g++; end
    chk("latency", 64'(cyc - t_last), 64'd3);
    st = cyc;
    wait_q(0, 16, 100);
    chk("throughput", 64'(cyc - st), 64'd16);
    check_frame(0, 64, 12'h123, 1, "f64");

    // non-matching unicast is discarded silently, broadcast to another port is kept
    send_frame(0, 64, {1'b0, 6'(PID + 1)}, 12'h0AA, 2);
    repeat (20) @(posedge clk_fabric);
    #1;
    chk("other_port_nothing", 64'(qa.size()), 64'd0);
    chk("other_port_nodrop", 64'(drop_count_a), 64'd0);
    send_frame(0, 64, {1'b1, 6'(PID + 1)}, 12'h0AA, 3);
    check_frame(0, 64, 12'h0AA, 3, "bcast");

    // 61-byte frame: last tx beat carries one byte
    send_frame(0, 61, {1'b0, 6'(PID)}, 12'h456, 4);
    check_frame(0, 61, 12'h456, 4, "f61");
    repeat (10) @(posedge clk_fabric);
    #1;
    chk("f61_no_extra", 64'(qa.size()), 64'd0);

    // DEPTH=16: oversized frame dropped, following short frame survives
    send_frame(1, 160, {1'b0, 6'(PID)}, 12'h789, 5);
    send_frame(1, 32, {1'b0, 6'(PID)}, 12'h321, 6);
    repeat (10) @(posedge clk_fabric);
    #1;
    chk("small_drop_count", 64'(drop_count_b), 64'd1);
    chk("small_held", 64'(qb.size()), 64'd0);
    chk("small_tvalid_held", 64'(tx_tvalid_b), 64'd1);
    tx_tready_b = 1'b1;
    check_frame(1, 32, 12'h321, 6, "small");
    repeat (20) @(posedge clk_fabric);
    #1;
    chk("small_no_extra", 64'(qb.size()), 64'd0);

    // two 128-byte frames with tx_tready toggling every cycle
    tx_tready_a = 1'b0;
    fork
      begin
        send_frame(0, 128, {1'b0, 6'(PID)}, 12'hABC, 7);
        send_frame(0, 128, {1'b0, 6'(PID)}, 12'hDEF, 8);
      end
      begin
        int i = 0;
        while (qa.size() < 64 && i < 2000) begin
          @(posedge clk_fabric); #1;
          tx_tready_a = ~tx_tready_a;
          i++;
        end
      end
    join
    tx_tready_a = 1'b1;
    chk("toggle_total", 64'(qa.size()), 64'd64);
    check_frame(0, 128, 12'hABC, 7, "tog1");
    check_frame(0, 128, 12'hDEF, 8, "tog2");

    // reset mid-output, then a clean frame
    send_frame(0, 64, {1'b0, 6'(PID)}, 12'h5A5, 9);
    wait_q(0, 4, 50);
    rst = 1'b1;
    @(posedge clk_fabric); #1;
    chk("rst_mid_tvalid", 64'(tx_tvalid_a), 64'd0);
    chk("rst_mid_rx_tready", 64'(rx_tready_a), 64'd0);
    rst = 1'b0;
    qa.delete();
    repeat (20) @(posedge clk_fabric);
    #1;
    chk("rst_flushed", 64'(qa.size()), 64'd0);
    send_frame(0, 64, {1'b0, 6'(PID)}, 12'h2B4, 10);
    check_frame(0, 64, 12'h2B4, 10, "post_rst");
    chk("final_drop_a", 64'(drop_count_a), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
